// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM encoding, oversampling
// constants and the per-rate tick divisors for a 50 MHz clock.
package uart_pkg;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    // Oversampling: 16 ticks per bit, mid-bit of the start bit at sample 7
    localparam int         OVERSAMPLE  = 16;
    localparam logic [3:0] MID_SAMPLE  = 4'd7;
    localparam logic [3:0] LAST_SAMPLE = 4'(OVERSAMPLE - 1);

    // Clock cycles per oversample tick
    localparam logic [7:0] DIV_19200  = 8'd163;
    localparam logic [7:0] DIV_38400  = 8'd81;
    localparam logic [7:0] DIV_76800  = 8'd41;
    localparam logic [7:0] DIV_153600 = 8'd20;

    // Map a rate select code onto its tick divisor
    function automatic logic [7:0] baud_divisor(input logic [1:0] sel);
        logic [7:0] div;
        case (sel)
            2'b00:   div = DIV_19200;
            2'b01:   div = DIV_38400;
            2'b10:   div = DIV_76800;
            2'b11:   div = DIV_153600;
            default: div = DIV_19200;
        endcase
        return div;
    endfunction

endpackage

// File: rtl/uart_rx_tick_gen.sv
// 16x oversample tick generator. The counter runs 0..div-1 and the tick is
// high while the counter sits at div-1; clr restarts the bit timing so the
// first tick of a frame lands a full tick period after the start edge.
module uart_rx_tick_gen
    import uart_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic [1:0] baud_sel,
    output logic       tick
);

    logic [7:0] r_cnt;
    logic [7:0] w_div_m1;

    assign w_div_m1 = baud_divisor(baud_sel) - 8'd1;
    assign tick     = (r_cnt == w_div_m1);

    // Tick counter: clear on reset or frame start, otherwise count and wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= 8'd0;
        end else if (clr) begin
            r_cnt <= 8'd0;
        end else if (r_cnt >= w_div_m1) begin
            // >= keeps the counter bounded even if the divisor ever shrinks
            r_cnt <= 8'd0;
        end else begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1, 16x oversampled. The line is synchronised, a falling
// edge starts a frame, the start bit is re-checked at mid-bit, data bits and
// the stop bit are sampled at their centres. All outputs are registered.
module uart_rx
    import uart_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] baud_rate,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
    output logic       busy
);

    logic       r_sync1;
    logic       r_sync2;
    logic       r_hist;
    logic [1:0] r_state;
    logic [1:0] r_frame_baud;
    logic [3:0] r_sample_cnt;
    logic [2:0] r_bit_idx;
    logic [7:0] r_shift;
    logic [7:0] r_data_out;
    logic       r_data_valid;
    logic       r_frame_err;
    logic       r_busy;

    logic       w_rx;
    logic       w_fall;
    logic       w_tick;
    logic       w_start_det;
    logic       w_mid_start;
    logic       w_mid_bit;
    logic [1:0] w_state_nxt;

    assign w_rx        = r_sync2;
    assign w_fall      = r_hist & ~r_sync2;
    assign w_mid_start = w_tick & (r_sample_cnt == MID_SAMPLE);
    assign w_mid_bit   = w_tick & (r_sample_cnt == LAST_SAMPLE);

    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign frame_err  = r_frame_err;
    assign busy       = r_busy;

    uart_rx_tick_gen u_tick_gen (
        .clk      (clk),
        .rst      (rst),
        .clr      (w_start_det),
        .baud_sel (r_frame_baud),
        .tick     (w_tick)
    );

    // Two-flop synchroniser plus history flop; idle-high after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_hist  <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
            r_hist  <= r_sync2;
        end
    end

    // Next-state decode for the frame FSM
    always_comb begin
        w_state_nxt = r_state;
        w_start_det = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_fall) begin
                    w_state_nxt = ST_START;
                    w_start_det = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_START: begin
                if (w_mid_start) begin
                    // A line back high at mid start bit was only a glitch
                    w_state_nxt = w_rx ? ST_IDLE : ST_DATA;
                end else begin
                    w_state_nxt = ST_START;
                end
            end
            ST_DATA: begin
                if (w_mid_bit && (r_bit_idx == 3'd7)) begin
                    w_state_nxt = ST_STOP;
                end else begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_STOP: begin
                if (w_mid_bit) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_STOP;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register and busy flag, kept in lock-step with the state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
        end
    end

    // Frame rate latch, sample counter, bit index and shift register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_baud <= 2'b00;
            r_sample_cnt <= 4'd0;
            r_bit_idx    <= 3'd0;
            r_shift      <= 8'h00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start_det) begin
                        r_frame_baud <= baud_rate;
                        r_sample_cnt <= 4'd0;
                        r_bit_idx    <= 3'd0;
                    end
                end
                ST_START: begin
                    if (w_mid_start) begin
                        // Realign so later samples fall 16 ticks apart from here
                        r_sample_cnt <= 4'd0;
                    end else if (w_tick) begin
                        r_sample_cnt <= r_sample_cnt + 4'd1;
                    end
                end
                ST_DATA: begin
                    if (w_tick) begin
                        r_sample_cnt <= r_sample_cnt + 4'd1;
                    end
                    if (w_mid_bit) begin
                        r_shift   <= {w_rx, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                    end
                end
                ST_STOP: begin
                    if (w_tick) begin
                        r_sample_cnt <= r_sample_cnt + 4'd1;
                    end
                end
                default: begin
                    r_sample_cnt <= 4'd0;
                    r_bit_idx    <= 3'd0;
                end
            endcase
        end
    end

    // Output register: data_out and single-cycle result pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_out   <= 8'h00;
            r_data_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_data_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            if ((r_state == ST_STOP) && w_mid_bit) begin
                if (w_rx) begin
                    r_data_out   <= r_shift;
                    r_data_valid <= 1'b1;
                end else begin
                    r_frame_err  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx. Frames are driven bit by bit at exactly
// 16*divisor clocks per bit; the expected result of each frame follows from
// the framing rules alone (good stop bit -> byte, low stop bit -> error).
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] baud_rate;
    logic       rx;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       busy;

    typedef struct packed {
        logic       is_err;
        logic [7:0] data;
    } ev_t;

    ev_t        ev_q[$];
    ev_t        exp_q[$];
    int         errors = 0;
    int         checks = 0;
    logic [7:0] last_good = 8'h00;
    logic       prev_valid = 1'b0;
    logic       prev_err = 1'b0;

    uart_rx dut (
        .clk        (clk),
        .rst        (rst),
        .baud_rate  (baud_rate),
        .rx         (rx),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Capture every result pulse and check pulse exclusivity / width
    always @(posedge clk) begin
        #1;
        if (data_valid || frame_err) begin
            checks++;
            if (data_valid && frame_err) begin
                errors++;
                $display("FAIL pulse_exclusive: data_valid=%b frame_err=%b, required never both", data_valid, frame_err);
            end
            checks++;
            if ((data_valid && prev_valid) || (frame_err && prev_err)) begin
                errors++;
                $display("FAIL pulse_width: pulse held two cycles (valid %b->%b err %b->%b), required one cycle",
                         prev_valid, data_valid, prev_err, frame_err);
            end
            ev_q.push_back(ev_t'{is_err: frame_err, data: data_out});
        end
        prev_valid = data_valid;
        prev_err   = frame_err;
    end

    // Clocks per bit for a rate select: 16 ticks of the specified divisor
    function automatic int bit_clks(input logic [1:0] sel);
        int divs [4] = '{163, 81, 41, 20};
        return 16 * divs[sel];
    endfunction

    // Reference outcome of one frame from its stop bit
    function automatic ev_t model_frame(input logic [7:0] d, input logic stop_b);
        return stop_b ? ev_t'{is_err: 1'b0, data: d} : ev_t'{is_err: 1'b1, data: 8'h00};
    endfunction

    task automatic drive_bit(input logic b, input int n);
        rx = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input int n, input logic stop_b);
        drive_bit(1'b0, n);
        for (int i = 0; i < 8; i++) drive_bit(d[i], n);
        drive_bit(stop_b, n);
    endtask

    task automatic test_reset();
        rst = 1'b1; rx = 1'b1; baud_rate = 2'b11;
        repeat (4) @(negedge clk);
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data_out: got %h, required 00", data_out); end
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_data_valid: got %b, required 0", data_valid); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b, required 0", frame_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
        rst = 1'b0;
        ev_q.delete();
        drive_bit(1'b1, 20);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b, required 0", busy); end
        checks++; if (ev_q.size() != 0) begin errors++; $display("FAIL reset_idle_events: got %0d, required 0", ev_q.size()); end
    endtask

    task automatic test_basic();
        baud_rate = 2'b11;
        ev_q.delete();
        send_frame(8'hA5, bit_clks(2'b11), 1'b1);
        drive_bit(1'b1, 40);
        checks++;
        if (ev_q.size() != 1) begin
            errors++; $display("FAIL basic_count: got %0d events, required 1", ev_q.size());
        end else if (ev_q[0] !== model_frame(8'hA5, 1'b1)) begin
            errors++; $display("FAIL basic_event: got err=%b data=%h, required err=0 data=a5", ev_q[0].is_err, ev_q[0].data);
        end
        checks++; if (data_out !== 8'hA5) begin errors++; $display("FAIL basic_data_out: got %h, required a5", data_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy: got %b, required 0", busy); end
        last_good = 8'hA5;
    endtask

    task automatic test_back_to_back();
        baud_rate = 2'b00;
        ev_q.delete();
        exp_q.delete();
        send_frame(8'h00, bit_clks(2'b00), 1'b1);
        exp_q.push_back(model_frame(8'h00, 1'b1));
        send_frame(8'hFF, bit_clks(2'b00), 1'b1);
        exp_q.push_back(model_frame(8'hFF, 1'b1));
        drive_bit(1'b1, 40);
        checks++; if (ev_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_count: got %0d, required %0d", ev_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++) begin
            checks++;
            if (ev_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL b2b_event%0d: got err=%b data=%h, required err=%b data=%h",
                                   i, ev_q[i].is_err, ev_q[i].data, exp_q[i].is_err, exp_q[i].data);
            end
        end
        checks++; if (data_out !== 8'hFF) begin errors++; $display("FAIL b2b_data_out: got %h, required ff", data_out); end
        last_good = 8'hFF;
    endtask

    task automatic test_glitch();
        baud_rate = 2'b11;
        ev_q.delete();
        drive_bit(1'b0, 50);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_low: got %b, required 1", busy); end
        drive_bit(1'b0, 50);
        drive_bit(1'b1, 300);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_after: got %b, required 0", busy); end
        checks++; if (ev_q.size() != 0) begin errors++; $display("FAIL glitch_events: got %0d, required 0", ev_q.size()); end
    endtask

    task automatic test_frame_err();
        baud_rate = 2'b11;
        ev_q.delete();
        send_frame(8'h3C, bit_clks(2'b11), 1'b0);
        drive_bit(1'b0, 5 * bit_clks(2'b11));
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ferr_busy_held_low: got %b, required 0", busy); end
        drive_bit(1'b1, 100);
        checks++;
        if (ev_q.size() != 1) begin
            errors++; $display("FAIL ferr_count: got %0d events, required 1", ev_q.size());
        end else if (ev_q[0].is_err !== 1'b1) begin
            errors++; $display("FAIL ferr_kind: got err=%b, required err=1", ev_q[0].is_err);
        end
        checks++; if (data_out !== last_good) begin errors++; $display("FAIL ferr_data_out: got %h, required %h", data_out, last_good); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ferr_busy: got %b, required 0", busy); end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d;
        int         n;
        d = 8'h55;
        n = bit_clks(2'b11);
        baud_rate = 2'b11;
        ev_q.delete();
        drive_bit(1'b0, n);
        for (int i = 0; i < 4; i++) drive_bit(d[i], n);
        drive_bit(d[4], n / 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL midrst_data_out: got %h, required 00", data_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b, required 0", busy); end
        last_good = 8'h00;
        drive_bit(1'b1, 2 * n);
        checks++; if (ev_q.size() != 0) begin errors++; $display("FAIL midrst_events: got %0d, required 0", ev_q.size()); end
        send_frame(8'h81, n, 1'b1);
        drive_bit(1'b1, 40);
        checks++;
        if (ev_q.size() != 1) begin
            errors++; $display("FAIL midrst_next_count: got %0d, required 1", ev_q.size());
        end else if (ev_q[0] !== model_frame(8'h81, 1'b1)) begin
            errors++; $display("FAIL midrst_next_event: got err=%b data=%h, required err=0 data=81", ev_q[0].is_err, ev_q[0].data);
        end
        last_good = 8'h81;
    endtask

    task automatic test_baud_switch();
        logic [7:0] d;
        logic [7:0] d2;
        int         n;
        d  = 8'h96;
        d2 = 8'($urandom);
        n  = bit_clks(2'b11);
        baud_rate = 2'b11;
        ev_q.delete();
        exp_q.delete();
        drive_bit(1'b0, n);
        drive_bit(d[0], n);
        drive_bit(d[1], n);
        drive_bit(d[2], n / 2);
        baud_rate = 2'b10;
        drive_bit(d[2], n - n / 2);
        for (int i = 3; i < 8; i++) drive_bit(d[i], n);
        drive_bit(1'b1, n);
        exp_q.push_back(model_frame(d, 1'b1));
        drive_bit(1'b1, 40);
        send_frame(d2, bit_clks(2'b10), 1'b1);
        exp_q.push_back(model_frame(d2, 1'b1));
        drive_bit(1'b1, 60);
        checks++; if (ev_q.size() != exp_q.size()) begin errors++; $display("FAIL switch_count: got %0d, required %0d", ev_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++) begin
            checks++;
            if (ev_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL switch_event%0d: got err=%b data=%h, required err=%b data=%h",
                                   i, ev_q[i].is_err, ev_q[i].data, exp_q[i].is_err, exp_q[i].data);
            end
        end
        last_good = d2;
    endtask

    task automatic test_random();
        logic [1:0] rates [3] = '{2'b01, 2'b11, 2'b11};
        logic [7:0] d;
        logic       stop_b;
        ev_t        e;
        ev_q.delete();
        exp_q.delete();
        for (int f = 0; f < 3; f++) begin
            d         = 8'($urandom);
            stop_b    = ($urandom_range(3) != 0);
            baud_rate = rates[f];
            send_frame(d, bit_clks(rates[f]), stop_b);
            e = model_frame(d, stop_b);
            exp_q.push_back(e);
            if (stop_b) last_good = d;
            drive_bit(1'b1, $urandom_range(60, 10));
        end
        drive_bit(1'b1, 40);
        checks++; if (ev_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count: got %0d, required %0d", ev_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++) begin
            checks++;
            if ((ev_q[i].is_err !== exp_q[i].is_err) || (!exp_q[i].is_err && (ev_q[i].data !== exp_q[i].data))) begin
                errors++; $display("FAIL rand_event%0d: got err=%b data=%h, required err=%b data=%h",
                                   i, ev_q[i].is_err, ev_q[i].data, exp_q[i].is_err, exp_q[i].data);
            end
        end
        checks++; if (data_out !== last_good) begin errors++; $display("FAIL rand_data_out: got %h, required %h", data_out, last_good); end
    endtask

    initial begin
        rst       = 1'b1;
        rx        = 1'b1;
        baud_rate = 2'b11;
        test_reset();
        test_basic();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_mid_frame();
        test_baud_switch();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
